// File: rtl/load_store_unit_if.sv
// Bundle between the execute stage, load_store_unit and data_memory.
// slave = the load/store unit's view; master = the core/memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_mode;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  logic [31:0] mem_address;
  logic [1:0]  mem_mode;
  logic        mem_unsigned;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  modport slave (
    input  req_valid, req_write, req_mode, req_unsigned, req_address, req_wdata,
    input  mem_q,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_mode, mem_unsigned, mem_data, mem_wren
  );

  modport master (
    output req_valid, req_write, req_mode, req_unsigned, req_address, req_wdata,
    output mem_q,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_mode, mem_unsigned, mem_data, mem_wren
  );
endinterface

// File: rtl/load_store_unit.sv
// Core-side load/store initiator for data_memory; splits misaligned accesses.
// Define MISALIGN_TRAP_EN to reject misaligned requests with resp_error instead.
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input logic              clock,
  input logic              reset,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ACCESS     = 3'd1;
  localparam logic [2:0] WAIT       = 3'd2;
  localparam logic [2:0] RESP       = 3'd3;
`ifndef MISALIGN_TRAP_EN
  localparam logic [1:0] MEM_BYTE   = 2'd0;
  localparam logic [2:0] LD_HI      = 3'd4;
  localparam logic [2:0] LD_HI_WAIT = 3'd5;
  localparam logic [2:0] ST_BYTE    = 3'd6;
`endif

  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

  logic [2:0]  state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [1:0]  mem_mode_q, mem_mode_d;
  logic        mem_unsigned_q, mem_unsigned_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_wren_q, mem_wren_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        req_misaligned;

`ifdef MISALIGN_TRAP_EN
  logic        resp_error_q, resp_error_d;
`else
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  mode_q, mode_d;
  logic        unsigned_q, unsigned_d;
  logic        split_q, split_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] lo_q, lo_d;
  logic [1:0]  byte_nxt;
  logic [1:0]  byte_last;

  // Funnel the two aligned words down by the byte offset, then extend halves.
  function automatic logic [31:0] merge_words(input logic [31:0] hi, input logic [31:0] lo,
                                              input logic [1:0] off, input logic [1:0] mode,
                                              input logic uns);
    logic [31:0] m;
    m = 32'({hi, lo} >> {off, 3'b000});
    if (mode == MEM_HALF)
      return uns ? {16'h0000, m[15:0]} : {{16{m[15]}}, m[15:0]};
    return m;
  endfunction

  assign byte_nxt  = byte_cnt_q + 2'd1;
  assign byte_last = (mode_q == MEM_HALF) ? 2'd1 : 2'd3;
`endif

  assign req_misaligned = ((bus.req_mode == MEM_HALF) && (bus.req_address[1:0] == 2'b11)) ||
                          ((bus.req_mode == MEM_WORD) && (bus.req_address[1:0] != 2'b00));

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    wait_cnt_d     = wait_cnt_q;
    mem_address_d  = mem_address_q;
    mem_mode_d     = mem_mode_q;
    mem_unsigned_d = mem_unsigned_q;
    mem_data_d     = mem_data_q;
    mem_wren_d     = 1'b0;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = 32'h0;
`ifdef MISALIGN_TRAP_EN
    resp_error_d   = 1'b0;
`else
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    mode_d         = mode_q;
    unsigned_d     = unsigned_q;
    split_d        = split_q;
    byte_cnt_d     = byte_cnt_q;
    lo_d           = lo_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
`ifdef MISALIGN_TRAP_EN
          if (req_misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d        = ACCESS;
            mem_address_d  = bus.req_address;
            mem_mode_d     = bus.req_mode;
            mem_unsigned_d = bus.req_unsigned;
            mem_data_d     = bus.req_wdata;
            mem_wren_d     = bus.req_write;
          end
`else
          addr_d     = bus.req_address;
          wdata_d    = bus.req_wdata;
          mode_d     = bus.req_mode;
          unsigned_d = bus.req_unsigned;
          split_d    = req_misaligned;
          byte_cnt_d = 2'd0;
          if (req_misaligned && bus.req_write) begin
            state_d        = ST_BYTE;
            mem_address_d  = bus.req_address;
            mem_mode_d     = MEM_BYTE;
            mem_unsigned_d = 1'b1;
            mem_data_d     = {24'h0, bus.req_wdata[7:0]};
            mem_wren_d     = 1'b1;
          end else if (req_misaligned) begin
            // Low half of a split load: fetch the containing aligned word raw.
            state_d        = ACCESS;
            mem_address_d  = {bus.req_address[31:2], 2'b00};
            mem_mode_d     = MEM_WORD;
            mem_unsigned_d = 1'b1;
            mem_data_d     = bus.req_wdata;
          end else begin
            state_d        = ACCESS;
            mem_address_d  = bus.req_address;
            mem_mode_d     = bus.req_mode;
            mem_unsigned_d = bus.req_unsigned;
            mem_data_d     = bus.req_wdata;
            mem_wren_d     = bus.req_write;
          end
`endif
        end
      end

      ACCESS: begin
        if (write_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = LAT_INIT;
        end
      end

      WAIT: begin
        if (wait_cnt_q == 3'd0) begin
`ifndef MISALIGN_TRAP_EN
          if (split_q) begin
            state_d       = LD_HI;
            lo_d          = bus.mem_q;
            mem_address_d = {addr_q[31:2], 2'b00} + 32'd4;
          end else
`endif
          begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = bus.mem_q;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end

`ifndef MISALIGN_TRAP_EN
      LD_HI: begin
        state_d    = LD_HI_WAIT;
        wait_cnt_d = LAT_INIT;
      end

      LD_HI_WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = merge_words(bus.mem_q, lo_q, addr_q[1:0], mode_q, unsigned_q);
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end

      ST_BYTE: begin
        if (byte_cnt_q == byte_last) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          byte_cnt_d    = byte_nxt;
          mem_address_d = addr_q + {30'h0, byte_nxt};
          mem_data_d    = {24'h0, wdata_q[{byte_nxt, 3'b000} +: 8]};
          mem_wren_d    = 1'b1;
        end
      end
`endif

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= IDLE;
      write_q        <= 1'b0;
      wait_cnt_q     <= 3'd0;
      mem_address_q  <= 32'h0;
      mem_mode_q     <= 2'd0;
      mem_unsigned_q <= 1'b0;
      mem_data_q     <= 32'h0;
      mem_wren_q     <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      resp_error_q   <= 1'b0;
`else
      addr_q         <= 32'h0;
      wdata_q        <= 32'h0;
      mode_q         <= 2'd0;
      unsigned_q     <= 1'b0;
      split_q        <= 1'b0;
      byte_cnt_q     <= 2'd0;
      lo_q           <= 32'h0;
`endif
    end else begin
      state_q        <= state_d;
      write_q        <= write_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_address_q  <= mem_address_d;
      mem_mode_q     <= mem_mode_d;
      mem_unsigned_q <= mem_unsigned_d;
      mem_data_q     <= mem_data_d;
      mem_wren_q     <= mem_wren_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
`ifdef MISALIGN_TRAP_EN
      resp_error_q   <= resp_error_d;
`else
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      mode_q         <= mode_d;
      unsigned_q     <= unsigned_d;
      split_q        <= split_d;
      byte_cnt_q     <= byte_cnt_d;
      lo_q           <= lo_d;
`endif
    end
  end

  assign bus.req_ready    = (state_q == IDLE) && reset;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.mem_address  = mem_address_q;
  assign bus.mem_mode     = mem_mode_q;
  assign bus.mem_unsigned = mem_unsigned_q;
  assign bus.mem_data     = mem_data_q;
  assign bus.mem_wren     = mem_wren_q;
`ifdef MISALIGN_TRAP_EN
  assign bus.resp_error   = resp_error_q;
`else
  assign bus.resp_error   = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a behavioural data_memory model,
// with scoreboard queues for memory writes and responses.
module tb_load_store_unit;
  localparam int LAT = 2;
  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  load_store_unit_if lsu_bus ();

  load_store_unit #(.READ_LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (lsu_bus)
  );

  // data_memory stand-in: LAT-stage read pipeline, lane-aware writes
  logic [7:0]  mem_model [256];
  logic [31:0] q_pipe [LAT];
  assign lsu_bus.mem_q = q_pipe[LAT-1];

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] mode,
                                             input logic uns);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem_model[a[7:0]];
    b1 = mem_model[a[7:0] + 8'd1];
    b2 = mem_model[a[7:0] + 8'd2];
    b3 = mem_model[a[7:0] + 8'd3];
    case (mode)
      MEM_BYTE: return uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
      MEM_HALF: return uns ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default:  return {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clock) begin
    q_pipe[0] <= model_read(lsu_bus.mem_address, lsu_bus.mem_mode, lsu_bus.mem_unsigned);
    for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
    if (lsu_bus.mem_wren) begin
      mem_model[lsu_bus.mem_address[7:0]] <= lsu_bus.mem_data[7:0];
      if (lsu_bus.mem_mode != MEM_BYTE)
        mem_model[lsu_bus.mem_address[7:0] + 8'd1] <= lsu_bus.mem_data[15:8];
      if (lsu_bus.mem_mode == MEM_WORD) begin
        mem_model[lsu_bus.mem_address[7:0] + 8'd2] <= lsu_bus.mem_data[23:16];
        mem_model[lsu_bus.mem_address[7:0] + 8'd3] <= lsu_bus.mem_data[31:24];
      end
    end
  end

  logic [65:0] wr_exp_q[$];
  logic [32:0] resp_exp_q[$];
  int total = 0;
  int passed = 0;
  int failed = 0;
  int wren_cnt = 0;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h (failure #%0d)", tag, obs, exp, failed);
    end
  endtask

  // Scoreboard pops on every write cycle and every response pulse.
  always @(negedge clock) begin
    logic [65:0] we;
    logic [32:0] re;
    if (lsu_bus.mem_wren) begin
      wren_cnt++;
      check("write_expected", 66'(wr_exp_q.size() != 0), 66'(1));
      if (wr_exp_q.size() != 0) begin
        we = wr_exp_q.pop_front();
        check("mem_write", {lsu_bus.mem_mode, lsu_bus.mem_address, lsu_bus.mem_data}, we);
      end
    end
    if (lsu_bus.resp_valid) begin
      check("resp_expected", 66'(resp_exp_q.size() != 0), 66'(1));
      if (resp_exp_q.size() != 0) begin
        re = resp_exp_q.pop_front();
        check("resp_data", 66'({lsu_bus.resp_error, lsu_bus.resp_rdata}), 66'(re));
      end
    end
  end

  task automatic txn(input logic wr, input logic [1:0] mode, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata);
    logic mis;
    int n, exp_lat, exp_wren, base, cycles;
    mis = ((mode == MEM_HALF) && (addr[1:0] == 2'b11)) ||
          ((mode == MEM_WORD) && (addr[1:0] != 2'b00));
    n = (mode == MEM_HALF) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
    if (mis) begin
      exp_lat = 1;
      exp_wren = 0;
      resp_exp_q.push_back({1'b1, 32'h0});
    end else
`endif
    if (wr) begin
      resp_exp_q.push_back({1'b0, 32'h0});
      if (mis) begin
        for (int i = 0; i < n; i++)
          wr_exp_q.push_back({MEM_BYTE, addr + 32'(i), 24'h0, wdata[8*i +: 8]});
        exp_lat = n + 1;
        exp_wren = n;
      end else begin
        wr_exp_q.push_back({mode, addr, wdata});
        exp_lat = 2;
        exp_wren = 1;
      end
    end else begin
      resp_exp_q.push_back({1'b0, exp_rdata});
      exp_wren = 0;
      exp_lat = mis ? 2*LAT + 3 : LAT + 2;
    end

    base = wren_cnt;
    lsu_bus.req_valid = 1'b1;
    lsu_bus.req_write = wr;
    lsu_bus.req_mode = mode;
    lsu_bus.req_unsigned = uns;
    lsu_bus.req_address = addr;
    lsu_bus.req_wdata = wdata;
    for (int k = 0; k < 20 && !lsu_bus.req_ready; k++) @(negedge clock);
    check("req_ready", 66'(lsu_bus.req_ready), 66'(1));
    @(posedge clock);
    #1;
    lsu_bus.req_valid = 1'b0;
    lsu_bus.req_write = 1'($urandom);
    lsu_bus.req_mode = 2'($urandom);
    lsu_bus.req_unsigned = 1'($urandom);
    lsu_bus.req_address = $urandom;
    lsu_bus.req_wdata = $urandom;
    cycles = 0;
    while (cycles < 40) begin
      @(negedge clock);
      cycles++;
      if (lsu_bus.resp_valid) break;
    end
    check("latency", 66'(cycles), 66'(exp_lat));
    check("wren_count", 66'(wren_cnt - base), 66'(exp_wren));
    $display("txn %s mode=%0d uns=%0b addr=%08h rdata=%08h err=%0b cycles=%0d",
             wr ? "ST" : "LD", mode, uns, addr, lsu_bus.resp_rdata, lsu_bus.resp_error, cycles);
    @(negedge clock);
    check("resp_single_pulse", 66'(lsu_bus.resp_valid), 66'(0));
    check("ready_after_resp", 66'(lsu_bus.req_ready), 66'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr_before;
    int base;
    lsu_bus.req_valid = 1'b0;
    lsu_bus.req_write = 1'b0;
    lsu_bus.req_mode = MEM_BYTE;
    lsu_bus.req_unsigned = 1'b0;
    lsu_bus.req_address = 32'h0;
    lsu_bus.req_wdata = 32'h0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", 66'(lsu_bus.req_ready), 66'(0));
    check("rst_mem_wren", 66'(lsu_bus.mem_wren), 66'(0));
    check("rst_mem_bus", {lsu_bus.mem_mode, lsu_bus.mem_address, lsu_bus.mem_data}, 66'(0));
    check("rst_mem_unsigned", 66'(lsu_bus.mem_unsigned), 66'(0));
    check("rst_resp", 66'({lsu_bus.resp_valid, lsu_bus.resp_error, lsu_bus.resp_rdata}), 66'(0));
    reset = 1'b1;
    @(negedge clock);
    check("ready_after_reset", 66'(lsu_bus.req_ready), 66'(1));

    txn(1, MEM_WORD, 0, 32'h10, 32'h12345678, 32'h0);
    txn(0, MEM_WORD, 0, 32'h10, 32'h0, 32'h12345678);

`ifndef MISALIGN_TRAP_EN
    txn(1, MEM_WORD, 0, 32'h20, 32'h000080FF, 32'h0);
    txn(0, MEM_BYTE, 0, 32'h21, 32'h0, 32'hFFFFFF80);
    txn(0, MEM_BYTE, 1, 32'h21, 32'h0, 32'h00000080);
    txn(0, MEM_HALF, 0, 32'h20, 32'h0, 32'hFFFF80FF);
    txn(0, MEM_HALF, 1, 32'h22, 32'h0, 32'h00000000);

    txn(1, MEM_WORD, 0, 32'h30, 32'h44332211, 32'h0);
    txn(1, MEM_WORD, 0, 32'h34, 32'h88776655, 32'h0);
    txn(1, MEM_WORD, 0, 32'h38, 32'h000000F0, 32'h0);
    txn(0, MEM_WORD, 0, 32'h33, 32'h0, 32'h77665544);
    txn(0, MEM_HALF, 0, 32'h33, 32'h0, 32'h00005544);
    txn(0, MEM_WORD, 0, 32'h31, 32'h0, 32'h55443322);
    txn(0, MEM_HALF, 0, 32'h31, 32'h0, 32'h00003322);
    txn(0, MEM_HALF, 0, 32'h37, 32'h0, 32'hFFFFF088);
    txn(0, MEM_HALF, 1, 32'h37, 32'h0, 32'h0000F088);

    txn(1, MEM_WORD, 0, 32'h40, 32'h11111111, 32'h0);
    txn(1, MEM_WORD, 0, 32'h44, 32'h00000000, 32'h0);
    txn(1, MEM_WORD, 0, 32'h48, 32'h00000000, 32'h0);
    txn(1, MEM_WORD, 0, 32'h41, 32'hAABBCCDD, 32'h0);
    txn(0, MEM_WORD, 0, 32'h40, 32'h0, 32'hBBCCDD11);
    txn(0, MEM_WORD, 0, 32'h44, 32'h0, 32'h000000AA);
    txn(1, MEM_HALF, 0, 32'h47, 32'h1234BEEF, 32'h0);
    txn(0, MEM_WORD, 0, 32'h44, 32'h0, 32'hEF0000AA);
    txn(0, MEM_HALF, 1, 32'h47, 32'h0, 32'h0000BEEF);

    // address wrap on the second word of a split access
    txn(1, MEM_WORD, 0, 32'hFFFFFFFC, 32'hDDCCBBAA, 32'h0);
    txn(1, MEM_WORD, 0, 32'h00000000, 32'h44332211, 32'h0);
    txn(0, MEM_WORD, 0, 32'hFFFFFFFE, 32'h0, 32'h2211DDCC);
    txn(1, MEM_HALF, 0, 32'hFFFFFFFF, 32'h00005A6B, 32'h0);
    txn(0, MEM_WORD, 0, 32'h00000000, 32'h0, 32'h4433225A);

    // reset during the third byte of a split store
    txn(1, MEM_WORD, 0, 32'h50, 32'h00000000, 32'h0);
    wr_exp_q.push_back({MEM_BYTE, 32'h51, 32'h000000DD});
    wr_exp_q.push_back({MEM_BYTE, 32'h52, 32'h000000CC});
    wr_exp_q.push_back({MEM_BYTE, 32'h53, 32'h000000BB});
    base = wren_cnt;
    lsu_bus.req_valid = 1'b1;
    lsu_bus.req_write = 1'b1;
    lsu_bus.req_mode = MEM_WORD;
    lsu_bus.req_unsigned = 1'b0;
    lsu_bus.req_address = 32'h51;
    lsu_bus.req_wdata = 32'hAABBCCDD;
    @(posedge clock);
    #1;
    lsu_bus.req_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("split_third_wren", 66'(lsu_bus.mem_wren), 66'(1));
    check("split_third_addr", 66'(lsu_bus.mem_address), 66'(32'h53));
    reset = 1'b0;
    @(negedge clock);
    check("abort_wren", 66'(lsu_bus.mem_wren), 66'(0));
    check("abort_resp", 66'(lsu_bus.resp_valid), 66'(0));
    check("abort_ready_in_reset", 66'(lsu_bus.req_ready), 66'(0));
    reset = 1'b1;
    @(negedge clock);
    check("abort_ready_after", 66'(lsu_bus.req_ready), 66'(1));
    check("abort_wren_count", 66'(wren_cnt - base), 66'(3));
    repeat (3) begin
      @(negedge clock);
      check("abort_no_resp", 66'(lsu_bus.resp_valid), 66'(0));
    end
    txn(0, MEM_WORD, 0, 32'h50, 32'h0, 32'hBBCCDD00);
`else
    txn(1, MEM_WORD, 0, 32'h00, 32'hCAFE1234, 32'h0);
    addr_before = lsu_bus.mem_address;
    txn(0, MEM_HALF, 0, 32'h03, 32'h0, 32'h0);
    check("trap_addr_idle", 66'(lsu_bus.mem_address), 66'(addr_before));
    txn(0, MEM_HALF, 0, 32'h02, 32'h0, 32'hFFFFCAFE);
    txn(1, MEM_WORD, 0, 32'h41, 32'hAABBCCDD, 32'h0);
    txn(0, MEM_WORD, 0, 32'h33, 32'h0, 32'h0);
    txn(0, MEM_WORD, 0, 32'h00, 32'h0, 32'hCAFE1234);
`endif

    @(negedge clock);
    check("wr_queue_drained", 66'(wr_exp_q.size()), 66'(0));
    check("resp_queue_drained", 66'(resp_exp_q.size()), 66'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
